// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined single-precision multiplier.
// Optional feature macro: FMUL_FLAGS_EN (adds the 4-bit exception flag output).
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = 2**(EXP_W_DEF-1) - 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_multiplier_if.sv
// Operand/result handshake bundle for fp_multiplier.
// Optional feature macro: FMUL_FLAGS_EN (adds the flags signal).
interface fp_multiplier_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
`ifdef FMUL_FLAGS_EN
    logic [3:0]   flags;

    modport master (output in_valid, A, B, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, A, B, out_ready,
                    output in_ready, out_valid, result, flags);
`else
    modport master (output in_valid, A, B, out_ready,
                    input  in_ready, out_valid, result);
    modport slave  (input  in_valid, A, B, out_ready,
                    output in_ready, out_valid, result);
`endif
endinterface

// File: rtl/fp_mul_round.sv
// Combinational final stage: normalize the significand product, round to
// nearest-even, apply overflow-to-Inf / flush-to-zero, and pack the result.
// Optional feature macro: FMUL_FLAGS_EN (adds the flg output).
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                          sign,
    input  fp_class_t                     cls,
    input  logic signed [EXP_W+1:0]       esum,
    input  logic [2*MAN_W+1:0]            prod,
`ifdef FMUL_FLAGS_EN
    output logic [3:0]                    flg,
`endif
    output logic [EXP_W+MAN_W:0]          res
);
    localparam int PW = 2*MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] ONE  = 1;
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);

    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       frac_n;
    logic [MAN_W-1:0]       frac_r;
    logic                   guard;
    logic                   sticky;
    logic                   inc;
    logic                   carry;
    logic                   ovf;
    logic                   unf;
    logic signed [EW-1:0]   exp_n;
    logic signed [EW-1:0]   exp_r;

    // Normalize to a hidden-one at the top, round, and select the packed result
    always_comb begin
        // Product lies in [1,4); when >= 2 the hidden one is bit PW-1 and the exponent bumps
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_n  = prod[PW-1] ? esum + ONE : esum;
        frac_n = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
        inc    = guard & (sticky | frac_n[0]);
        // An all-ones fraction rounding up wraps to zero and renormalizes upward
        carry  = inc & (&frac_n);
        frac_r = frac_n + MAN_W'(inc);
        exp_r  = carry ? exp_n + ONE : exp_n;
        ovf    = (exp_r >= EMAX);
        unf    = exp_r[EW-1] | (exp_r == '0);

        res = '0;
        unique case (cls)
            NAN:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            INF:  res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: res = {sign, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                if (ovf)
                    res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (unf)
                    res = {sign, {(EXP_W+MAN_W){1'b0}}};
                else
                    res = {sign, exp_r[EXP_W-1:0], frac_r};
            end
        endcase

`ifdef FMUL_FLAGS_EN
        flg = '0;
        if (cls == NAN)
            flg[FLAG_INVALID] = 1'b1;
        if (cls == NORM) begin
            flg[FLAG_OVERFLOW]  = ovf;
            flg[FLAG_UNDERFLOW] = unf;
            flg[FLAG_INEXACT]   = guard | sticky | ovf | unf;
        end
`endif
    end

endmodule

// File: rtl/fp_multiplier.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready on both sides.
// A stalled output freezes every stage; in_ready is the inverse of that stall.
// Optional feature macro: FMUL_FLAGS_EN (adds the exception flag pipeline).
module fp_multiplier
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    fp_multiplier_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2*SW;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(2**(EXP_W-1) - 1);

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)
            return ZERO;   // subnormals are treated as zero
        else if (&e)
            return (m == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

    logic                 stall;
    logic                 vld_p0, vld_p1, vld_p2;
    fp_class_t            cls_a, cls_b, cls_s0;
    logic                 sign_s0;
    logic signed [EW-1:0] esum_s0;
    logic                 sign_p0, sign_p1;
    fp_class_t            cls_p0, cls_p1;
    logic signed [EW-1:0] esum_p0, esum_p1;
    logic [SW-1:0]        sig_a_p0, sig_b_p0;
    logic [PW-1:0]        prod_p1;
    logic [W-1:0]         res_s2;
    logic [W-1:0]         result_p2;

    assign stall        = vld_p2 & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;

    // Unpack: combined operand class, product sign and biased exponent sum
    always_comb begin
        cls_a   = classify(bus.A[W-2:MAN_W], bus.A[MAN_W-1:0]);
        cls_b   = classify(bus.B[W-2:MAN_W], bus.B[MAN_W-1:0]);
        sign_s0 = bus.A[W-1] ^ bus.B[W-1];
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO))
            cls_s0 = NAN;
        else if (cls_a == INF || cls_b == INF)
            cls_s0 = INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            cls_s0 = ZERO;
        else
            cls_s0 = NORM;
        esum_s0 = $signed({2'b00, bus.A[W-2:MAN_W]}) + $signed({2'b00, bus.B[W-2:MAN_W]}) - BIAS_S;
    end

    // Stage valid bits advance together whenever the output is not stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1/2 data registers: unpacked operands, then the significand product
    always_ff @(posedge clk) begin
        if (!stall) begin
            sign_p0  <= sign_s0;
            cls_p0   <= cls_s0;
            esum_p0  <= esum_s0;
            sig_a_p0 <= {1'b1, bus.A[MAN_W-1:0]};
            sig_b_p0 <= {1'b1, bus.B[MAN_W-1:0]};
            sign_p1  <= sign_p0;
            cls_p1   <= cls_p0;
            esum_p1  <= esum_p0;
            prod_p1  <= sig_a_p0 * sig_b_p0;
        end
    end

`ifdef FMUL_FLAGS_EN
    logic [3:0] flg_s2;
    logic [3:0] flags_p2;
    assign bus.flags = flags_p2;

    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign (sign_p1),
        .cls  (cls_p1),
        .esum (esum_p1),
        .prod (prod_p1),
        .flg  (flg_s2),
        .res  (res_s2)
    );

    // Stage 3: flags travel with the rounded result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flags_p2 <= '0;
        else if (!stall && vld_p1)
            flags_p2 <= flg_s2;
    end
`else
    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign (sign_p1),
        .cls  (cls_p1),
        .esum (esum_p1),
        .prod (prod_p1),
        .res  (res_s2)
    );
`endif

    // Stage 3: capture the rounded result only for valid stage-2 entries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            result_p2 <= '0;
        else if (!stall && vld_p1)
            result_p2 <= res_s2;
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed bench for fp_multiplier: arithmetic vectors, specials, backpressure
// and mid-flight reset. Flag checks are compiled in with FMUL_FLAGS_EN.
module tb_fp_multiplier;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fp_multiplier_if #(.W(32)) bus ();

    fp_multiplier dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Push one operand pair and check latency, result and flags
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_f);
        int n;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        checks++;
        assert (bus.result === exp_r)
        else begin
            errors++;
            $error("FAIL %s_res got %h want %h (flags want %b)", tag, bus.result, exp_r, exp_f);
        end
`ifdef FMUL_FLAGS_EN
        chk({tag, "_flags"}, {28'd0, bus.flags}, {28'd0, exp_f});
`endif
    endtask

    logic [31:0] bp_a   [6];
    logic [31:0] bp_exp [6];
    int sent, recv, cyc;

    initial begin
        checks = 0;
        errors = 0;
        bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

        // Reset state
        reset_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0;
        bus.B = '0;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_result",    bus.result,             32'd0);
`ifdef FMUL_FLAGS_EN
        chk("rst_flags", {28'd0, bus.flags}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Arithmetic and special cases
        run_op("basic",  32'h41400000, 32'h41200000, 32'h42F00000, 4'b0000);
        run_op("norm",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        run_op("round",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_op("zinf",   32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        run_op("ovf",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        run_op("unf",    32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_op("neg",    32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
        run_op("infneg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
        run_op("nan",    32'hFFC12345, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_op("subn",   32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000);

        // Backpressure: six back-to-back ops, output blocked for the first 5 cycles
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 6 && cyc < 40) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 5);
            bus.in_valid  = (sent < 6);
            bus.A = (sent < 6) ? bp_a[sent] : 32'h0;
            bus.B = 32'h40000000;
            #1;
            if (cyc == 4)
                chk("bp_in_ready_stalled", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp_res%0d", recv), bus.result, bp_exp[recv]);
                recv++;
            end
            if (bus.in_valid && bus.in_ready)
                sent++;
            cyc++;
        end
        chk("bp_recv_count", 32'(recv), 32'd6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_dup", {31'd0, bus.out_valid}, 32'd0);

        // Reset with two ops in flight
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.A = 32'h41400000;
        bus.B = 32'h41200000;
        @(negedge clk);
        bus.A = 32'h3FC00000;
        bus.B = 32'h3FC00000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_before", {31'd0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_result",    bus.result,             32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_discard", {31'd0, bus.out_valid}, 32'd0);
        run_op("post_rst", 32'h41400000, 32'h41200000, 32'h42F00000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
